gtp_drp_master: RTL and testbench
=================================

// Module: gtp_drp_master
// PURPOSE
//  Serialises register read/write requests from fabric logic onto the DRP port of one GTPE2_CHANNEL.
//  Sits directly upstream of the transceiver: drives DRPEN/DRPWE/DRPADDR/DRPDI and consumes DRPDO/DRPRDY.
//  Runs entirely in the DRPCLK domain: clk connects to DRPCLK.
//  Adds a per-access timeout so a missing DRPRDY cannot hang the requester.
// PARAMETERS
//  ADDR_W   9     DRP address width (GTPE2_CHANNEL = 9)
//  TIMEOUT  1023  cycles after drp_en to wait for drp_rdy; 0 = wait forever
// PORTS
//  clk        in   1       DRP clock, connected to DRPCLK; all logic rising-edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request valid
//  req_ready  out  1       request accepted when req_valid & req_ready
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  DRP address
//  req_wdata  in   16      write data
//  req_wmask  in   16      per-bit write enable; port exists only with GTP_DRP_RMW_EN
//  rsp_valid  out  1       one-cycle response strobe
//  rsp_rdata  out  16      read data (see below)
//  rsp_err    out  1       timeout flag, qualified by rsp_valid
//  busy       out  1       high in any state other than IDLE
//  drp_en     out  1       to DRPEN
//  drp_we     out  1       to DRPWE
//  drp_addr   out  ADDR_W  to DRPADDR
//  drp_di     out  16      to DRPDI
//  drp_do     in   16      from DRPDO
//  drp_rdy    in   1       from DRPRDY
// BEHAVIOUR
//  - Reset values: drp_en=0, drp_we=0, drp_addr=0, drp_di=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
//    req_ready=0 while rst is high; state returns to IDLE.
//  - FSM states: IDLE, ISSUE, WAIT, RESP; with GTP_DRP_RMW_EN also ISSUE_RD and WAIT_RD.
//  - req_ready = (state==IDLE) & ~rst. The request is captured on the accept cycle T.
//  - ISSUE (T+1): drp_en=1 for exactly one cycle, with drp_we/drp_addr/drp_di driven from the captured request.
//    drp_we/drp_addr/drp_di hold their values until the next issue.
//  - WAIT: counter c=1 on the cycle after drp_en and increments each cycle.
//    drp_rdy on the drp_en cycle itself is ignored.
//    If drp_rdy=1 at c<=TIMEOUT: capture drp_do and go to RESP with err=0.
//    If drp_rdy=1 on the cycle where c==TIMEOUT, rdy wins.
//    If no rdy by c==TIMEOUT: go to RESP with err=1 and rsp_rdata=0.
//  - RESP: rsp_valid=1 for one cycle, then IDLE unconditionally. There is no response backpressure.
//    Reads: rsp_rdata = captured drp_do. Writes: rsp_rdata = 0.
//  - Latency: drp_rdy at cycle R -> rsp_valid at R+1 -> req_ready high again at R+2.
//  - drp_rdy outside WAIT/WAIT_RD (late or spurious) is ignored and never generates a response.
//  - Exactly one drp_en per read or plain write; at most one DRP transaction is ever outstanding.
//  - rst during any state: the transaction is abandoned on the next edge.
//    No rsp_valid is produced and no further drp_en is issued.
// CONFIGURATION
//  GTP_DRP_RMW_EN defined:
//   - Every write becomes a read-modify-write: ISSUE_RD (drp_en, we=0), then WAIT_RD, then ISSUE (we=1,
//     drp_di = (old & ~req_wmask) | (req_wdata & req_wmask)), then WAIT, then RESP.
//   - rsp_rdata = old value.
//   - A timeout in WAIT_RD gives err=1 and no write is issued.
//   - A timeout in WAIT gives err=1 with rsp_rdata=0.
//   - Reads behave as in the base design.
//  GTP_DRP_RMW_EN undefined: no req_wmask port; writes are a single plain DRP write.
// TESTING
//  1 Read addr 0x011, DRP model returns 0x1234 with rdy 3 cycles after drp_en
//    -> one drp_en pulse at T+1 with we=0, addr=0x011; rsp_valid at T+5 with rdata=0x1234, err=0.
//  2 Write addr 0x05E, data 0xA5A5
//    -> one drp_en pulse with we=1, di=0xA5A5; rsp_valid with rdata=0x0000, err=0.
//  3 TIMEOUT=8, model never asserts rdy
//    -> rsp_valid with err=1 exactly 9 cycles after drp_en;
//       a drp_rdy injected 2 cycles later is ignored;
//       a following read completes normally.
//  4 req_valid held high across 2 back-to-back requests
//    -> req_ready low from T+1 until RESP+1; exactly 2 drp_en pulses; 2 rsp_valid strobes, in order.
//  5 rst asserted while in WAIT
//    -> next cycle all outputs at reset values; no rsp_valid even if drp_rdy arrives afterwards.
//  6 With GTP_DRP_RMW_EN: register holds 0xF0F0; write wdata=0x0FFF, wmask=0x00FF
//    -> read, then write with di=0xF0FF; rsp_rdata=0xF0F0, err=0.

Source files
------------

// File: rtl/gtp_drp_master.sv
// DRP master for one GTPE2_CHANNEL: serialises fabric read/write requests and times out missing DRPRDY.
// Define GTP_DRP_RMW_EN to turn every write into a masked read-modify-write (adds the req_wmask port).
module gtp_drp_master #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
`ifdef GTP_DRP_RMW_EN
  input  logic [15:0]       req_wmask,
`endif
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              drp_en,
  output logic              drp_we,
  output logic [ADDR_W-1:0] drp_addr,
  output logic [15:0]       drp_di,
  input  logic [15:0]       drp_do,
  input  logic              drp_rdy
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ISSUE_RD, S_WAIT_RD
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                drp_en_q, drp_en_d;
  logic                drp_we_q, drp_we_d;
  logic [ADDR_W-1:0]   drp_addr_q, drp_addr_d;
  logic [15:0]         drp_di_q, drp_di_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                accept_c;
  logic                timeout_c;
`ifdef GTP_DRP_RMW_EN
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         wmask_q, wmask_d;
  logic [15:0]         old_q, old_d;
`endif

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign accept_c  = req_valid & req_ready;
  // TIMEOUT of 0 disables the timeout; the counter is then free to wrap.
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign drp_en    = drp_en_q;
  assign drp_we    = drp_we_q;
  assign drp_addr  = drp_addr_q;
  assign drp_di    = drp_di_q;

  // Next-state and registered-output logic; drp_en is raised on entry to an issue state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    drp_en_d    = 1'b0;
    drp_we_d    = drp_we_q;
    drp_addr_d  = drp_addr_q;
    drp_di_d    = drp_di_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef GTP_DRP_RMW_EN
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    old_d       = old_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          we_d       = req_we;
          drp_en_d   = 1'b1;
          drp_addr_d = req_addr;
`ifdef GTP_DRP_RMW_EN
          wdata_d    = req_wdata;
          wmask_d    = req_wmask;
          drp_we_d   = 1'b0;
          state_d    = req_we ? S_ISSUE_RD : S_ISSUE;
`else
          drp_we_d   = req_we;
          drp_di_d   = req_wdata;
          state_d    = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (drp_rdy) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
`ifdef GTP_DRP_RMW_EN
          rsp_rdata_d = we_q ? old_q : drp_do;
`else
          rsp_rdata_d = we_q ? 16'h0000 : drp_do;
`endif
        end else if (timeout_c) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 16'h0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
`ifdef GTP_DRP_RMW_EN
      S_ISSUE_RD: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (drp_rdy) begin
          old_d    = drp_do;
          drp_en_d = 1'b1;
          drp_we_d = 1'b1;
          drp_di_d = (drp_do & ~wmask_q) | (wdata_q & wmask_q);
          state_d  = S_ISSUE;
        end else if (timeout_c) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 16'h0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      drp_en_q    <= 1'b0;
      drp_we_q    <= 1'b0;
      drp_addr_q  <= '0;
      drp_di_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GTP_DRP_RMW_EN
      wdata_q     <= '0;
      wmask_q     <= '0;
      old_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      drp_en_q    <= drp_en_d;
      drp_we_q    <= drp_we_d;
      drp_addr_q  <= drp_addr_d;
      drp_di_q    <= drp_di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifdef GTP_DRP_RMW_EN
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      old_q       <= old_d;
`endif
    end
  end

endmodule

// File: tb/tb_gtp_drp_master.sv
// Directed bench for gtp_drp_master (TIMEOUT=8); the RMW step runs only when GTP_DRP_RMW_EN is defined.
module tb_gtp_drp_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
`ifdef GTP_DRP_RMW_EN
  logic [15:0] req_wmask;
`endif
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        drp_en;
  logic        drp_we;
  logic [8:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_rdy;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int rv_cnt   = 0;
  int en0, rv0;

  gtp_drp_master #(.ADDR_W(9), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef GTP_DRP_RMW_EN
    .req_wmask(req_wmask),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_rdy(drp_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (drp_en === 1'b1) en_cnt++;
    if (rsp_valid === 1'b1) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one request for a single accept edge; returns on the drp_en (ISSUE) cycle.
  task automatic request(input logic we, input logic [8:0] addr, input logic [15:0] wdata,
                         input logic [15:0] wmask);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef GTP_DRP_RMW_EN
    req_wmask = wmask;
`else
    if (wmask != 16'h0) req_wdata = wdata;
`endif
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_drp_en"},    32'(drp_en),    32'h0);
    chk({pfx, "_drp_we"},    32'(drp_we),    32'h0);
    chk({pfx, "_drp_addr"},  32'(drp_addr),  32'h0);
    chk({pfx, "_drp_di"},    32'(drp_di),    32'h0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({pfx, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
    chk({pfx, "_rsp_err"},   32'(rsp_err),   32'h0);
    chk({pfx, "_busy"},      32'(busy),      32'h0);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef GTP_DRP_RMW_EN
    req_wmask = '0;
`endif
    drp_do = '0; drp_rdy = 1'b0;
    step(3);
    chk_reset_values("reset");
    rst = 1'b0;
    #1 chk("ready_after_reset", 32'(req_ready), 32'h1);
    step(1);

    // 1: read 0x011, rdy three cycles after drp_en
    request(1'b0, 9'h011, 16'h0, 16'h0);
    chk("t1_en",    32'(drp_en),    32'h1);
    chk("t1_we",    32'(drp_we),    32'h0);
    chk("t1_addr",  32'(drp_addr),  32'h011);
    chk("t1_busy",  32'(busy),      32'h1);
    chk("t1_ready", 32'(req_ready), 32'h0);
    step(1);
    chk("t1_en_once", 32'(drp_en), 32'h0);
    step(2);
    chk("t1_no_early_rsp", 32'(rsp_valid), 32'h0);
    drp_rdy = 1'b1; drp_do = 16'h1234;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rdata",     32'(rsp_rdata), 32'h1234);
    chk("t1_err",       32'(rsp_err),   32'h0);
    step(1);
    chk("t1_rsp_once",  32'(rsp_valid), 32'h0);
    chk("t1_ready_again", 32'(req_ready), 32'h1);

`ifndef GTP_DRP_RMW_EN
    // 2: plain write 0x05E <- 0xA5A5
    request(1'b1, 9'h05E, 16'hA5A5, 16'h0);
    chk("t2_en",   32'(drp_en),   32'h1);
    chk("t2_we",   32'(drp_we),   32'h1);
    chk("t2_addr", 32'(drp_addr), 32'h05E);
    chk("t2_di",   32'(drp_di),   32'hA5A5);
    step(1);
    drp_rdy = 1'b1; drp_do = 16'hFFFF;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t2_rdata",     32'(rsp_rdata), 32'h0);
    chk("t2_err",       32'(rsp_err),   32'h0);
    step(1);
`endif

    // 3: timeout after 8 WAIT cycles, late rdy ignored, then a normal read
    request(1'b0, 9'h022, 16'h0, 16'h0);
    chk("t3_en", 32'(drp_en), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("t3_no_early_rsp", 32'(rsp_valid), 32'h0);
    end
    step(1);
    chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t3_err",       32'(rsp_err),   32'h1);
    chk("t3_rdata",     32'(rsp_rdata), 32'h0);
    step(2);
    rv0 = rv_cnt;
    drp_rdy = 1'b1; drp_do = 16'hBEEF;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    step(2);
    chk("t3_late_rdy_rsp", 32'(rv_cnt - rv0), 32'h0);
    chk("t3_late_rdy_busy", 32'(busy), 32'h0);
    request(1'b0, 9'h033, 16'h0, 16'h0);
    chk("t3b_en", 32'(drp_en), 32'h1);
    step(1);
    drp_rdy = 1'b1; drp_do = 16'h5678;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    chk("t3b_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t3b_rdata",     32'(rsp_rdata), 32'h5678);
    chk("t3b_err",       32'(rsp_err),   32'h0);
    step(1);

    // 4: req_valid held across two back-to-back reads
    en0 = en_cnt; rv0 = rv_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h040;
    step(1);
    req_addr = 9'h041;
    chk("t4_en1",     32'(drp_en),    32'h1);
    chk("t4_addr1",   32'(drp_addr),  32'h040);
    chk("t4_ready_n1", 32'(req_ready), 32'h0);
    step(1);
    chk("t4_ready_n2", 32'(req_ready), 32'h0);
    drp_rdy = 1'b1; drp_do = 16'h0040;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    chk("t4_rsp1_valid", 32'(rsp_valid), 32'h1);
    chk("t4_rsp1_rdata", 32'(rsp_rdata), 32'h0040);
    chk("t4_ready_resp", 32'(req_ready), 32'h0);
    step(1);
    chk("t4_ready_resp1", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 1'b0;
    chk("t4_en2",   32'(drp_en),   32'h1);
    chk("t4_addr2", 32'(drp_addr), 32'h041);
    step(1);
    drp_rdy = 1'b1; drp_do = 16'h0041;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    chk("t4_rsp2_valid", 32'(rsp_valid), 32'h1);
    chk("t4_rsp2_rdata", 32'(rsp_rdata), 32'h0041);
    step(2);
    chk("t4_en_pulses",  32'(en_cnt - en0), 32'h2);
    chk("t4_rsp_strobes", 32'(rv_cnt - rv0), 32'h2);

    // 5: reset while in WAIT abandons the transaction
    en0 = en_cnt; rv0 = rv_cnt;
    request(1'b0, 9'h055, 16'h0, 16'h0);
    step(1);
    rst = 1'b1;
    step(1);
    chk_reset_values("t5");
    rst = 1'b0;
    drp_rdy = 1'b1; drp_do = 16'h1111;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    step(3);
    chk("t5_no_rsp",   32'(rv_cnt - rv0), 32'h0);
    chk("t5_one_en",   32'(en_cnt - en0), 32'h1);
    chk("t5_busy",     32'(busy),         32'h0);
    chk("t5_ready",    32'(req_ready),    32'h1);

`ifdef GTP_DRP_RMW_EN
    // 6: read-modify-write of 0xF0F0 with wdata 0x0FFF, wmask 0x00FF
    request(1'b1, 9'h066, 16'h0FFF, 16'h00FF);
    chk("t6_rd_en",   32'(drp_en),   32'h1);
    chk("t6_rd_we",   32'(drp_we),   32'h0);
    chk("t6_rd_addr", 32'(drp_addr), 32'h066);
    step(1);
    drp_rdy = 1'b1; drp_do = 16'hF0F0;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    chk("t6_wr_en",    32'(drp_en),    32'h1);
    chk("t6_wr_we",    32'(drp_we),    32'h1);
    chk("t6_wr_di",    32'(drp_di),    32'hF0FF);
    chk("t6_no_early", 32'(rsp_valid), 32'h0);
    step(1);
    drp_rdy = 1'b1; drp_do = 16'h1234;
    step(1);
    drp_rdy = 1'b0; drp_do = 16'h0;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t6_rdata",     32'(rsp_rdata), 32'hF0F0);
    chk("t6_err",       32'(rsp_err),   32'h0);
    step(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
